// File: rtl/ram_sync_read_be_clr.sv
// Simple-dual-port synchronous RAM for the cache data and tag arrays.
// It has byte-lane write enables, a selectable read-during-write result and
// a clear sequencer. The sequencer sweeps every entry to CLR_VALUE after
// reset and whenever clear is requested.
module ram_sync_read_be_clr #(
  parameter int                AWIDTH    = 3,
  parameter int                DWIDTH    = 32,
  parameter int                RDW_MODE  = 0,
  parameter logic [DWIDTH-1:0] CLR_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  output logic                  ready,
  input  logic                  we,
  input  logic [AWIDTH-1:0]     waddr,
  input  logic [DWIDTH-1:0]     din,
  input  logic [DWIDTH/8-1:0]   be,
  input  logic                  re,
  input  logic [AWIDTH-1:0]     raddr,
  output logic [DWIDTH-1:0]     dout,
  output logic                  dout_valid
);

  localparam int DEPTH  = 1 << AWIDTH;
  localparam int NBYTES = DWIDTH / 8;

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state;
  state_t              state_next;
  logic [AWIDTH-1:0]   clr_cnt;
  logic [NBYTES-1:0]   wr_lane;
  logic [AWIDTH-1:0]   wr_addr;
  logic [DWIDTH-1:0]   wr_data;
  logic                rd_accept;
  logic [DWIDTH-1:0]   rd_data;

  logic [DWIDTH-1:0]   mem [DEPTH];

  // State register: reset always starts a fresh sweep.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= CLEAR;
    else       state <= state_next;
  end

  // Next state: finish the sweep on the last entry; clear restarts or enters it.
  always_comb begin
    // NOTE: default first so no path leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      CLEAR: if (!clear && clr_cnt == AWIDTH'(DEPTH - 1)) state_next = READY;
      READY: if (clear) state_next = CLEAR;
      default: state_next = CLEAR;
    endcase
  end

  // Output decode: ready comes straight from the state flop.
  always_comb begin
    ready = (state == READY);
  end

  // Sweep counter: advances while clearing, wraps to 0 after the last entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                clr_cnt <= '0;
    else if (clear)           clr_cnt <= '0;
    else if (state == CLEAR)  clr_cnt <= clr_cnt + 1'b1;
  end

  // Write port select: the sweep owns the port while clearing; user writes
  // are dropped on a clear edge.
  always_comb begin
    wr_lane = '0;
    wr_addr = waddr;
    wr_data = din;
    if (state == CLEAR) begin
      wr_lane = '1;
      wr_addr = clr_cnt;
      wr_data = CLR_VALUE;
    end else if (!clear && we) begin
      wr_lane = be;
    end
  end

  // Byte-lane write into the array.
  // NOTE: the array has no reset; the clear sweep gives it known contents.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NBYTES; i++) begin
      if (wr_lane[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  // Read data: old contents, or new bytes merged in when RDW_MODE is 1.
  always_comb begin
    rd_accept = (state == READY) && !clear && re;
    rd_data   = mem[raddr];
    if (RDW_MODE == 1 && wr_addr == raddr) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wr_lane[i]) rd_data[8*i +: 8] = din[8*i +: 8];
      end
    end
  end

  // Registered read port: dout holds when no read is accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= rd_accept;
      if (rd_accept) dout <= rd_data;
    end
  end

endmodule
